// File: rtl/l2_block_responder.sv
// Block-granular L2 responder: critical-word-first fills, in-order writebacks.
// Backing store is a word array indexed by {block, word offset}.
module l2_block_responder #(
  parameter int DEPTH_WORDS = 4096,
  parameter int RD_LATENCY  = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_wr_data,
  input  logic        i_wr_valid,
  output logic        o_wr_ready,
  output logic [31:0] o_rd_data,
  output logic        o_rd_valid,
  output logic [1:0]  o_rd_beat,
  output logic        o_rd_last,
  output logic        o_wr_done,
  output logic        o_err,
  output logic        o_busy
);

  localparam int NBLK = DEPTH_WORDS / 4;
  localparam int BW   = (NBLK > 1) ? $clog2(NBLK) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_BURST,
    S_WR_BURST,
    S_WR_ACK
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [BW-1:0] r_blk;
  logic [1:0]    r_crit;
  logic [1:0]    r_beat;
  logic [3:0]    r_cnt;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_oob;
  logic          w_wr_fire;
  logic [1:0]    w_rd_off;
  logic [BW+1:0] w_rd_idx;
  logic [BW+1:0] w_wr_idx;
  logic          w_unused_ok;

  assign w_accept  = i_req_valid && (r_state == S_IDLE);
  assign w_oob     = i_req_addr[31:4] >= 28'(NBLK);
  assign w_wr_fire = i_wr_valid && (r_state == S_WR_BURST);
  assign w_rd_off  = r_crit + r_beat;
  assign w_rd_idx  = {r_blk, w_rd_off};
  assign w_wr_idx  = {r_blk, r_beat};
  assign w_unused_ok = ^i_req_addr[1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_blk   <= '0;
      r_crit  <= 2'd0;
      r_beat  <= 2'd0;
      r_cnt   <= 4'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_accept && w_oob;
      if (w_accept && !w_oob) begin
        r_blk  <= i_req_addr[BW+3:4];
        r_crit <= i_req_addr[3:2];
        r_beat <= 2'd0;
        r_cnt  <= 4'(RD_LATENCY - 1);
      end else begin
        unique case (r_state)
          S_RD_WAIT: begin
            if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
          end
          S_RD_BURST: r_beat <= r_beat + 2'd1;
          S_WR_BURST: begin
            if (w_wr_fire) r_beat <= r_beat + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Store is never reset; a reset mid-writeback keeps beats already taken.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_wr_fire) r_mem[w_wr_idx] <= i_wr_data;
  end

  always_comb begin
    w_next      = r_state;
    o_req_ready = 1'b0;
    o_wr_ready  = 1'b0;
    o_rd_valid  = 1'b0;
    o_rd_data   = 32'd0;
    o_rd_beat   = 2'd0;
    o_rd_last   = 1'b0;
    o_wr_done   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid && !w_oob)
          w_next = i_req_we ? S_WR_BURST : S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (r_cnt == 4'd0) w_next = S_RD_BURST;
      end
      S_RD_BURST: begin
        o_rd_valid = 1'b1;
        o_rd_data  = r_mem[w_rd_idx];
        o_rd_beat  = w_rd_off;
        o_rd_last  = (r_beat == 2'd3);
        if (r_beat == 2'd3) w_next = S_IDLE;
      end
      S_WR_BURST: begin
        o_wr_ready = 1'b1;
        if (w_wr_fire && r_beat == 2'd3) w_next = S_WR_ACK;
      end
      S_WR_ACK: begin
        o_wr_done = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign o_err  = r_err;
  assign o_busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_l2_block_responder.sv
// Randomized bench for l2_block_responder against a word-array model
// of the backing store with spec-level burst ordering and timing.
module tb_l2_block_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        i_req_we = 1'b0;
  logic [31:0] i_req_addr = '0;
  logic [31:0] i_wr_data = '0;
  logic        i_wr_valid = 1'b0;
  logic        o_req_ready, o_wr_ready, o_rd_valid, o_rd_last;
  logic        o_wr_done, o_err, o_busy;
  logic [31:0] o_rd_data;
  logic [1:0]  o_rd_beat;

  l2_block_responder #(.DEPTH_WORDS(4096), .RD_LATENCY(LAT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_addr(i_req_addr),
    .i_wr_data(i_wr_data), .i_wr_valid(i_wr_valid),
    .o_wr_ready(o_wr_ready), .o_rd_data(o_rd_data),
    .o_rd_valid(o_rd_valid), .o_rd_beat(o_rd_beat),
    .o_rd_last(o_rd_last), .o_wr_done(o_wr_done),
    .o_err(o_err), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] model [int];
  int blocks_q [$];

  int f_lat, f_nb, f_last, f_lastcnt;
  logic [1:0]  f_off [8];
  logic [31:0] f_dat [8];
  int w_done_cnt, w_done_cyc, w_rdy_drop;
  logic [31:0] w_dat [4];

  function automatic int widx(input logic [31:0] a, input int off);
    return int'(a[31:4]) * 4 + off;
  endfunction

  task automatic req_issue(input logic [31:0] a, input logic we);
    int t;
    t = 0;
    i_req_addr = a;
    i_req_we = we;
    i_req_valid = 1'b1;
    while (!o_req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (t >= 100) begin
      n_err++;
      $display("FAIL req_timeout got %0d cycles exp <100", t);
    end
    @(negedge clk);
    i_req_valid = 1'b0;
  endtask

  task automatic do_fill(input logic [31:0] a);
    req_issue(a, 1'b0);
    f_nb = 0; f_lat = -1; f_last = -1; f_lastcnt = 0;
    for (int c = 1; c <= 16; c++) begin
      if (o_rd_valid) begin
        if (f_nb < 8) begin
          f_off[f_nb] = o_rd_beat;
          f_dat[f_nb] = o_rd_data;
        end
        if (f_lat < 0) f_lat = c;
        if (o_rd_last) begin
          f_last = f_nb;
          f_lastcnt++;
        end
        f_nb++;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input int gap);
    req_issue(a, 1'b1);
    w_rdy_drop = 0;
    for (int b = 0; b < 4; b++) begin
      if (b == gap) begin
        repeat (2) begin
          i_wr_valid = 1'b0;
          if (!o_wr_ready) w_rdy_drop++;
          @(negedge clk);
        end
      end
      i_wr_valid = 1'b1;
      i_wr_data = w_dat[b];
      if (!o_wr_ready) w_rdy_drop++;
      @(negedge clk);
    end
    i_wr_valid = 1'b0;
    w_done_cnt = 0; w_done_cyc = -1;
    for (int c = 1; c <= 6; c++) begin
      if (o_wr_done) begin
        w_done_cnt++;
        if (w_done_cyc < 0) w_done_cyc = c;
      end
      @(negedge clk);
    end
    for (int b = 0; b < 4; b++) model[widx(a, b)] = w_dat[b];
    blocks_q.push_back(int'(a[31:4]));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_addr = 32'h100;
    i_wr_valid = 1'b1; i_wr_data = 32'hDEAD;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({o_req_ready, o_wr_ready, o_rd_valid, o_rd_last,
         o_wr_done, o_err, o_busy} !== 7'b1000000) begin
      n_err++;
      $display("FAIL reset_ctrl got %b exp 1000000",
        {o_req_ready, o_wr_ready, o_rd_valid, o_rd_last,
         o_wr_done, o_err, o_busy});
    end
    n_vec++;
    if (o_rd_data !== 32'd0 || o_rd_beat !== 2'd0) begin
      n_err++;
      $display("FAIL reset_data got %h/%0d exp 0/0", o_rd_data, o_rd_beat);
    end
    i_req_valid = 1'b0; i_wr_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wb_fill();
    w_dat[0] = 32'hA0; w_dat[1] = 32'hA1;
    w_dat[2] = 32'hA2; w_dat[3] = 32'hA3;
    do_write(32'h100, -1);
    n_vec++;
    if (w_done_cnt !== 1 || w_done_cyc !== 1) begin
      n_err++;
      $display("FAIL wb_done got cnt=%0d cyc=%0d exp 1/1", w_done_cnt, w_done_cyc);
    end
    do_fill(32'h100);
    n_vec++;
    if (f_lat !== LAT + 1 || f_nb !== 4) begin
      n_err++;
      $display("FAIL fill_lat got lat=%0d nb=%0d exp %0d/4", f_lat, f_nb, LAT + 1);
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (f_off[i] !== 2'(i) || f_dat[i] !== 32'hA0 + 32'(i)) begin
        n_err++;
        $display("FAIL fill_beat%0d got %0d:%h exp %0d:%h",
          i, f_off[i], f_dat[i], i, 32'hA0 + 32'(i));
      end
    end
    n_vec++;
    if (f_last !== 3 || f_lastcnt !== 1) begin
      n_err++;
      $display("FAIL fill_last got pos=%0d cnt=%0d exp 3/1", f_last, f_lastcnt);
    end
  endtask

  task automatic test_wrap();
    do_fill(32'h10C);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (f_off[i] !== 2'((3 + i) % 4) ||
          f_dat[i] !== model[widx(32'h10C, (3 + i) % 4)]) begin
        n_err++;
        $display("FAIL wrap_beat%0d got %0d:%h exp %0d:%h", i, f_off[i],
          f_dat[i], (3 + i) % 4, model[widx(32'h10C, (3 + i) % 4)]);
      end
    end
    n_vec++;
    if (f_last !== 3 || f_off[3] !== 2'd2) begin
      n_err++;
      $display("FAIL wrap_last got pos=%0d off=%0d exp 3/2", f_last, f_off[3]);
    end
  endtask

  task automatic test_wr_gaps();
    for (int b = 0; b < 4; b++) w_dat[b] = $urandom;
    do_write(32'h208, 2);
    n_vec++;
    if (w_rdy_drop !== 0 || w_done_cnt !== 1) begin
      n_err++;
      $display("FAIL gap_wb got drop=%0d done=%0d exp 0/1", w_rdy_drop, w_done_cnt);
    end
    do_fill(32'h200);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (f_dat[i] !== model[widx(32'h200, i)]) begin
        n_err++;
        $display("FAIL gap_word%0d got %h exp %h", i, f_dat[i], model[widx(32'h200, i)]);
      end
    end
  endtask

  task automatic test_err();
    logic [31:0] addrs [2];
    logic        wes [2];
    int e_cnt, e_cyc, b_cnt, v_cnt, d_cnt;
    addrs[0] = 32'h4000; wes[0] = 1'b0;
    addrs[1] = 32'hFFFF_FFF4; wes[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      i_req_valid = 1'b1; i_req_addr = addrs[k]; i_req_we = wes[k];
      @(negedge clk);
      i_req_valid = 1'b0;
      e_cnt = 0; e_cyc = -1; b_cnt = 0; v_cnt = 0; d_cnt = 0;
      for (int c = 1; c <= 8; c++) begin
        if (o_err) begin
          e_cnt++;
          if (e_cyc < 0) e_cyc = c;
        end
        if (o_busy) b_cnt++;
        if (o_rd_valid) v_cnt++;
        if (o_wr_done) d_cnt++;
        @(negedge clk);
      end
      n_vec++;
      if (e_cnt !== 1 || e_cyc !== 1) begin
        n_err++;
        $display("FAIL err_pulse%0d got cnt=%0d cyc=%0d exp 1/1", k, e_cnt, e_cyc);
      end
      n_vec++;
      if (b_cnt !== 0 || v_cnt !== 0 || d_cnt !== 0) begin
        n_err++;
        $display("FAIL err_quiet%0d got busy=%0d rdv=%0d done=%0d exp 0/0/0",
          k, b_cnt, v_cnt, d_cnt);
      end
    end
  endtask

  task automatic test_rst_abort();
    int nb, t, v_cnt, d_cnt;
    req_issue(32'h200, 1'b0);
    nb = 0; t = 0;
    while (nb < 2 && t < 20) begin
      if (o_rd_valid) nb++;
      if (nb < 2) begin
        @(negedge clk);
        t++;
      end
    end
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (o_rd_valid !== 1'b0 || o_req_ready !== 1'b1 || o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL rd_abort got v=%b rdy=%b busy=%b exp 0/1/0",
        o_rd_valid, o_req_ready, o_busy);
    end
    rst = 1'b0;
    v_cnt = 0;
    repeat (6) begin
      if (o_rd_valid) v_cnt++;
      @(negedge clk);
    end
    n_vec++;
    if (v_cnt !== 0) begin
      n_err++;
      $display("FAIL rd_abort_tail got %0d beats exp 0", v_cnt);
    end
    do_fill(32'h200);
    n_vec++;
    if (f_nb !== 4 || f_dat[1] !== model[widx(32'h200, 1)]) begin
      n_err++;
      $display("FAIL post_rst_fill got nb=%0d d=%h exp 4/%h",
        f_nb, f_dat[1], model[widx(32'h200, 1)]);
    end
    // Writeback aborted after two beats; a beat offered with reset is dropped.
    for (int b = 0; b < 4; b++) w_dat[b] = $urandom;
    do_write(32'h300, -1);
    req_issue(32'h300, 1'b1);
    for (int b = 0; b < 2; b++) begin
      i_wr_valid = 1'b1; i_wr_data = 32'hC0DE_0000 + 32'(b);
      model[widx(32'h300, b)] = i_wr_data;
      @(negedge clk);
    end
    i_wr_data = 32'hBAD0_0002;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; i_wr_valid = 1'b0;
    n_vec++;
    if (o_wr_ready !== 1'b0 || o_req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL wr_abort got wrdy=%b rdy=%b exp 0/1", o_wr_ready, o_req_ready);
    end
    d_cnt = 0;
    repeat (5) begin
      if (o_wr_done) d_cnt++;
      @(negedge clk);
    end
    n_vec++;
    if (d_cnt !== 0) begin
      n_err++;
      $display("FAIL wr_abort_done got %0d exp 0", d_cnt);
    end
    do_fill(32'h300);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (f_dat[i] !== model[widx(32'h300, i)]) begin
        n_err++;
        $display("FAIL wr_abort_word%0d got %h exp %h", i, f_dat[i], model[widx(32'h300, i)]);
      end
    end
  endtask

  task automatic test_wr_ignored();
    int r_cnt;
    r_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      i_wr_valid = 1'b1; i_wr_data = $urandom;
      if (o_wr_ready) r_cnt++;
      @(negedge clk);
    end
    i_wr_valid = 1'b0;
    n_vec++;
    if (r_cnt !== 0) begin
      n_err++;
      $display("FAIL idle_wr_ready got %0d exp 0", r_cnt);
    end
    do_fill(32'h300);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (f_dat[i] !== model[widx(32'h300, i)]) begin
        n_err++;
        $display("FAIL idle_wr_word%0d got %h exp %h", i, f_dat[i], model[widx(32'h300, i)]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc, acc2_cyc, last_cyc, nb;
    acc = 0; acc2_cyc = -1; last_cyc = -1; nb = 0;
    i_req_valid = 1'b1; i_req_addr = 32'h100; i_req_we = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (o_rd_valid) begin
        if (nb < 8) begin
          f_off[nb] = o_rd_beat;
          f_dat[nb] = o_rd_data;
        end
        if (o_rd_last && last_cyc < 0) last_cyc = cyc;
        nb++;
      end
      if (i_req_valid && o_req_ready) begin
        acc++;
        if (acc == 2) acc2_cyc = cyc;
      end
      @(negedge clk);
      if (acc == 1) i_req_addr = 32'h208;
      if (acc >= 2) i_req_valid = 1'b0;
    end
    i_req_valid = 1'b0;
    n_vec++;
    if (acc !== 2 || acc2_cyc !== last_cyc + 1) begin
      n_err++;
      $display("FAIL b2b_accept got acc=%0d at %0d exp 2 at %0d", acc, acc2_cyc, last_cyc + 1);
    end
    n_vec++;
    if (nb !== 8) begin
      n_err++;
      $display("FAIL b2b_beats got %0d exp 8", nb);
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (f_dat[i] !== model[widx(32'h100, i)] ||
          f_dat[4 + i] !== model[widx(32'h200, (2 + i) % 4)]) begin
        n_err++;
        $display("FAIL b2b_beat%0d got %h/%h exp %h/%h", i, f_dat[i], f_dat[4 + i],
          model[widx(32'h100, i)], model[widx(32'h200, (2 + i) % 4)]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int blk, c;
    for (int it = 0; it < 12; it++) begin
      a = {20'h0, 8'($urandom_range(64, 79)), 4'($urandom_range(0, 15))};
      for (int b = 0; b < 4; b++) w_dat[b] = $urandom;
      do_write(a, $urandom_range(0, 4) - 1);
      n_vec++;
      if (w_done_cnt !== 1 || w_rdy_drop !== 0) begin
        n_err++;
        $display("FAIL rnd_wb%0d got done=%0d drop=%0d exp 1/0", it, w_done_cnt, w_rdy_drop);
      end
      blk = blocks_q[$urandom_range(0, blocks_q.size() - 1)];
      c = $urandom_range(0, 3);
      a = (32'(blk) << 4) | (32'(c) << 2) | 32'($urandom_range(0, 3));
      do_fill(a);
      n_vec++;
      if (f_lat !== LAT + 1 || f_nb !== 4 || f_last !== 3) begin
        n_err++;
        $display("FAIL rnd_fill%0d got lat=%0d nb=%0d last=%0d exp %0d/4/3",
          it, f_lat, f_nb, f_last, LAT + 1);
      end
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (f_off[i] !== 2'((c + i) % 4) ||
            f_dat[i] !== model[widx(a, (c + i) % 4)]) begin
          n_err++;
          $display("FAIL rnd_beat%0d_%0d got %0d:%h exp %0d:%h", it, i, f_off[i],
            f_dat[i], (c + i) % 4, model[widx(a, (c + i) % 4)]);
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_wb_fill();
    test_wrap();
    test_wr_gaps();
    test_err();
    test_rst_abort();
    test_wr_ignored();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/l2_block_responder.md
L2_BLOCK_RESPONDER -- requirements
Module: l2_block_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 4096, backing store size in 32-bit words (multiple of 4).
REQ-002 SHALL have parameter RD_LATENCY, default 2, idle cycles between read-request acceptance and first read beat (range 1-15).
REQ-003 One clock; reset is synchronous and active-high: CLK  input  1  rising-edge clock; RST  input  1  synchronous active-high reset.
REQ-004 REQ_VALID  input  1  requester has a block request.
REQ-005 REQ_READY  output  1  responder accepts request this cycle.
REQ-006 REQ_WE  input  1  1 = block writeback, 0 = block fill.
REQ-007 REQ_ADDR  input  32  byte address; [31:4] block, [3:2] critical word, [1:0] ignored.
REQ-008 WR_DATA  input  32  writeback beat data.
REQ-009 WR_VALID  input  1  writeback beat present.
REQ-010 WR_READY  output  1  responder accepts writeback beat.
REQ-011 RD_DATA  output  32  fill beat data.
REQ-012 RD_VALID  output  1  fill beat valid; no backpressure.
REQ-013 RD_BEAT  output  2  word offset within block of current fill beat.
REQ-014 RD_LAST  output  1  high with fourth fill beat.
REQ-015 WR_DONE  output  1  one-cycle pulse, writeback committed.
REQ-016 ERR  output  1  one-cycle pulse, request block outside DEPTH_WORDS.
REQ-017 BUSY  output  1  high in any state except IDLE.

Function
REQ-018 States: IDLE, RD_WAIT, RD_BURST, WR_BURST, WR_ACK; only IDLE drives REQ_READY=1.
REQ-019 Request accepted on REQ_VALID&REQ_READY; REQ_ADDR and REQ_WE captured that edge, ignored afterwards.
REQ-020 Range check at acceptance: REQ_ADDR[31:4] >= DEPTH_WORDS/4 -> ERR=1 next cycle, state stays IDLE, no memory access.
REQ-021 Fill: IDLE -> RD_WAIT for RD_LATENCY cycles -> RD_BURST; first RD_VALID exactly RD_LATENCY+1 cycles after acceptance edge.
REQ-022 RD_BURST emits 4 beats on consecutive cycles, critical word first: offsets c, c+1, c+2, c+3 mod 4 (wrap within block), c = captured addr[3:2].
REQ-023 RD_DATA = mem[block*4 + RD_BEAT] when RD_VALID=1; RD_DATA = 0 when RD_VALID=0.
REQ-024 RD_LAST=1 only on fourth beat; next cycle IDLE.
REQ-025 Writeback: IDLE -> WR_BURST; WR_READY=1 throughout WR_BURST; beats always offsets 0,1,2,3 in order regardless of addr[3:2].
REQ-026 Each WR_VALID&WR_READY writes WR_DATA to mem[block*4 + beat] that edge; beat counter advances only on handshake; WR_VALID gaps stall, no timeout.
REQ-027 After fourth handshake -> WR_ACK (WR_DONE=1 one cycle) -> IDLE.
REQ-028 Fill after writeback to same block returns newly written data (no stale read).
REQ-029 REQ_VALID while BUSY is held by requester; not lost, not accepted until IDLE.
REQ-030 WR_VALID outside WR_BURST ignored; memory unchanged.
REQ-031 Back-to-back: request may be accepted the cycle after RD_LAST or WR_DONE.

Reset
REQ-032 RST=1 at edge -> IDLE; REQ_READY=1, WR_READY=0, RD_VALID=0, RD_DATA=0, RD_BEAT=0, RD_LAST=0, WR_DONE=0, ERR=0, BUSY=0 next cycle.
REQ-033 RST during any burst aborts it; no further beats or WR_DONE; beats already written persist.
REQ-034 Memory contents unaffected by RST; zero at time 0.
REQ-035 RST has priority over simultaneous REQ_VALID/WR_VALID.

Verification
REQ-036 Writeback 0x100 beats 0xA0,0xA1,0xA2,0xA3 -> WR_DONE one cycle after fourth handshake; fill 0x100 -> beats 0..3 = 0xA0..0xA3, first RD_VALID 3 cycles after accept.
REQ-037 Fill 0x10C after block written -> RD_BEAT 3,0,1,2 with matching data; RD_LAST on beat offset 2.
REQ-038 Writeback with WR_VALID low 2 cycles between beats 1 and 2 -> WR_READY held, 4 words correct, WR_DONE once.
REQ-039 Request addr 0x4000 with DEPTH_WORDS=4096 -> ERR pulse, BUSY stays 0, no RD_VALID/WR_DONE.
REQ-040 RST asserted after second fill beat -> RD_VALID=0 next cycle, REQ_READY=1; subsequent fill completes normally.
REQ-041 REQ_VALID held through busy fill -> second request accepted cycle after RD_LAST, exactly once.
